clic_gateway: RTL and testbench
===============================

CLIC_GATEWAY -- requirements
Module: clic_gateway

Interface
REQ-001 SHALL have parameter N_SOURCE, default 32, number of interrupt sources.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth per source, legal range 2..4.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port irq_src_i  input  N_SOURCE  raw asynchronous interrupt lines.
REQ-006 SHALL have port le_i  input  N_SOURCE  trigger type per source, from clicintattr.trig[0]; 1 = edge, 0 = level.
REQ-007 SHALL have port pol_i  input  N_SOURCE  polarity per source, from clicintattr.trig[1]; 0 = active-high/rising, 1 = active-low/falling.
REQ-008 SHALL have port sw_set_i  input  N_SOURCE  one-cycle software set-pending pulses.
REQ-009 SHALL have port sw_clr_i  input  N_SOURCE  one-cycle software clear-pending pulses.
REQ-010 SHALL have port claim_valid_i  input  1  core acknowledges one interrupt this cycle.
REQ-011 SHALL have port claim_id_i  input  $clog2(N_SOURCE)  index of the acknowledged source.
REQ-012 SHALL have port ip_o  output  N_SOURCE  pending vector; drives the register adapter ip_i.
REQ-013 SHALL have port overrun_o  output  N_SOURCE  sticky per-source lost-edge flags.
REQ-014 SHALL have port claim_err_o  output  1  one-cycle pulse on an out-of-range claim.

Function
REQ-015 SHALL pass each irq_src_i bit through SYNC_STAGES flops; the last stage output is sync[i].
REQ-016 SHALL register sync[i] into prev[i] every cycle, in both modes and with raw polarity, so that a pol_i or le_i change never produces a false edge.
REQ-017 SHALL detect an edge as sync & ~prev when pol_i=0, and as ~sync & prev when pol_i=1.
REQ-018 Level mode (le_i=0): pending is set to sync ^ pol_i every cycle; sw_set_i, sw_clr_i and claims are ignored.
REQ-019 Edge mode (le_i=1): pending is set by a detected edge or sw_set_i, and cleared by sw_clr_i or a claim whose claim_id_i equals i; otherwise it holds.
REQ-020 Edge mode, simultaneous set and clear in one cycle: set wins and pending stays 1, so a new edge is never lost.
REQ-021 SHALL drive ip_o directly from the pending flops, with no combinational path from inputs.
REQ-022 Latency: an irq_src_i change held stable SHALL appear on ip_o exactly SYNC_STAGES+1 cycles later (edge in edge mode, level in level mode); sw_set_i/sw_clr_i SHALL appear 1 cycle later.
REQ-023 Overrun: in edge mode, a detected edge while pending is already 1 and no clear occurs that cycle SHALL set overrun_o[i]; it is cleared only by sw_clr_i[i] or reset.
REQ-024 A claim with claim_id_i >= N_SOURCE SHALL change no state and SHALL pulse claim_err_o for 1 cycle, registered.
REQ-025 A claim on a level-mode source SHALL not clear pending, and SHALL not raise claim_err_o.
REQ-026 Switching le_i from 1 to 0 SHALL make pending track the level on the next cycle; switching from 0 to 1 SHALL hold the current pending value until an edge or clear.
REQ-027 Only one claim per cycle; claim_id_i is don't-care when claim_valid_i=0.

Reset
REQ-028 Asserting rst_i SHALL asynchronously clear all synchronizer, prev, pending and overrun flops, plus claim_err_o; all outputs read 0 while reset is asserted.
REQ-029 After rst_i deasserts, a source held active through reset SHALL produce no edge-mode pending, because prev also reset to 0 and the edge appears only through the synchronizer. Exception: a source active-high at deassert with pol=0 is a legitimate rising edge and sets pending after SYNC_STAGES+1 cycles.
REQ-030 Reset asserted mid-operation SHALL discard pending edges; no pulse SHALL survive reset.

Verification
REQ-031 Edge, pol=0, SYNC_STAGES=2: irq_src_i[3] rises at cycle 0 -> ip_o[3]=1 at cycle 3; claim id 3 at cycle 5 -> ip_o[3]=0 at cycle 6.
REQ-032 Level, pol=1: irq_src_i[7] goes 1 to 0 -> ip_o[7]=1 three cycles later; source returns to 1 -> ip_o[7]=0 three cycles later; claim id 7 has no effect.
REQ-033 Edge on source 5 in the same cycle as claim id 5 while pending -> ip_o[5] stays 1 and overrun_o[5] stays 0; a second edge with no claim -> overrun_o[5]=1; sw_clr_i[5] -> ip_o[5]=0 and overrun_o[5]=0.
REQ-034 Toggle pol_i[2] with irq_src_i[2] static in edge mode -> ip_o[2] stays 0; claim_id_i=N_SOURCE (when N_SOURCE is not a power of 2) -> claim_err_o=1 for 1 cycle, ip_o unchanged.
REQ-035 Assert rst_i asynchronously mid-cycle with several pendings set -> ip_o=0, overrun_o=0 immediately; hold irq_src_i=1 with pol=1 through reset -> no pending after release.

Source files
------------

// File: rtl/clic_gateway.sv
// clic_gateway: per-source interrupt gateway for a CLIC.
// Each raw line is synchronized and edge-detected, then turned into a pending bit
// (level or edge mode). Edge-mode pendings are set/cleared by software and claims.
// Sticky overrun flags record lost edges. Out-of-range claims raise a registered error pulse.
module clic_gateway #(
    parameter int N_SOURCE    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_SOURCE-1:0]         irq_src_i,
    input  logic [N_SOURCE-1:0]         le_i,
    input  logic [N_SOURCE-1:0]         pol_i,
    input  logic [N_SOURCE-1:0]         sw_set_i,
    input  logic [N_SOURCE-1:0]         sw_clr_i,
    input  logic                        claim_valid_i,
    input  logic [$clog2(N_SOURCE)-1:0] claim_id_i,
    output logic [N_SOURCE-1:0]         ip_o,
    output logic [N_SOURCE-1:0]         overrun_o,
    output logic                        claim_err_o
);

    localparam int ID_W = $clog2(N_SOURCE);
    localparam logic [ID_W:0] N_LIMIT = (ID_W+1)'(N_SOURCE);

    logic [SYNC_STAGES-1:0][N_SOURCE-1:0] sync_q, sync_d;
    logic [N_SOURCE-1:0] prev_q, prev_d;
    logic [N_SOURCE-1:0] pend_q, pend_d;
    logic [N_SOURCE-1:0] ovr_q, ovr_d;
    logic                claim_err_q, claim_err_d;

    logic [N_SOURCE-1:0] sync;
    logic [N_SOURCE-1:0] edge_det;
    logic [N_SOURCE-1:0] claim_hit;
    logic [N_SOURCE-1:0] set_vec;
    logic [N_SOURCE-1:0] clr_vec;
    logic [N_SOURCE-1:0] pend_edge;
    logic [N_SOURCE-1:0] pend_level;
    logic                claim_in_range;

    // Synchronizer shift and raw-polarity history of the synchronized line
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = irq_src_i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        sync   = sync_q[SYNC_STAGES-1];
        prev_d = sync;
    end

    // Edge detection, claim decode and next pending/overrun/error state
    always_comb begin
        // prev holds raw polarity, so changing pol_i alone never looks like an edge
        edge_det       = (sync & ~prev_q & ~pol_i) | (~sync & prev_q & pol_i);
        claim_in_range = claim_valid_i && ({1'b0, claim_id_i} < N_LIMIT);
        claim_hit      = '0;
        for (int i = 0; i < N_SOURCE; i++) begin
            if (claim_in_range && (claim_id_i == ID_W'(i))) begin
                claim_hit[i] = 1'b1;
            end
        end
        set_vec    = edge_det | sw_set_i;
        clr_vec    = sw_clr_i | claim_hit;
        // set has priority so an edge coinciding with a clear is not lost
        pend_edge  = set_vec | (pend_q & ~clr_vec);
        pend_level = sync ^ pol_i;
        pend_d     = (le_i & pend_edge) | (~le_i & pend_level);
        ovr_d      = (ovr_q & ~sw_clr_i) | (le_i & edge_det & pend_q & ~clr_vec);
        claim_err_d = claim_valid_i && !claim_in_range;
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q      <= '0;
            prev_q      <= '0;
            pend_q      <= '0;
            ovr_q       <= '0;
            claim_err_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            claim_err_q <= claim_err_d;
        end
    end

    assign ip_o        = pend_q;
    assign overrun_o   = ovr_q;
    assign claim_err_o = claim_err_q;

endmodule

// File: tb/tb_clic_gateway.sv
// tb_clic_gateway: directed vector table, randomized run against a reference model,
// and reset corner sequences for clic_gateway (20 sources, 2 sync stages).
module tb_clic_gateway;

    localparam int NS = 20;
    localparam int S  = 2;
    localparam int IW = $clog2(NS);

    localparam logic [NS-1:0] LA = 20'hFFFFF;
    localparam logic [NS-1:0] L7 = 20'hFFF7F;
    localparam logic [NS-1:0] Z  = 20'h00000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NS-1:0] irq = '0, le = LA, pol = '0, sw_set = '0, sw_clr = '0;
    logic          cv = 1'b0;
    logic [IW-1:0] cid = '0;
    logic [NS-1:0] ip, ov;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    clic_gateway #(.N_SOURCE(NS), .SYNC_STAGES(S)) dut (
        .clk_i(clk), .rst_i(rst), .irq_src_i(irq), .le_i(le), .pol_i(pol),
        .sw_set_i(sw_set), .sw_clr_i(sw_clr), .claim_valid_i(cv), .claim_id_i(cid),
        .ip_o(ip), .overrun_o(ov), .claim_err_o(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [NS-1:0] irq, le, pol, set, clr;
        logic          cv;
        logic [IW-1:0] cid;
        logic [NS-1:0] ip, ov;
        logic          err;
    } vec_t;

    vec_t tab[$];

    task automatic add(input int n, input logic [NS-1:0] a_irq, input logic [NS-1:0] a_le,
                       input logic [NS-1:0] a_pol, input logic [NS-1:0] a_set,
                       input logic [NS-1:0] a_clr, input logic a_cv, input logic [IW-1:0] a_cid,
                       input logic [NS-1:0] e_ip, input logic [NS-1:0] e_ov, input logic e_err);
        vec_t v;
        v.irq = a_irq; v.le = a_le; v.pol = a_pol; v.set = a_set; v.clr = a_clr;
        v.cv = a_cv; v.cid = a_cid; v.ip = e_ip; v.ov = e_ov; v.err = e_err;
        for (int k = 0; k < n; k++) tab.push_back(v);
    endtask

    // ---------------- reference model ----------------
    // Line delay history: m_hist[k] is the input seen k edges before the current one.
    logic [NS-1:0] m_hist [0:S];
    logic [NS-1:0] m_pend, m_ov;
    logic          m_err;

    task automatic model_reset();
        for (int k = 0; k <= S; k++) m_hist[k] = '0;
        m_pend = '0; m_ov = '0; m_err = 1'b0;
    endtask

    task automatic model_step();
        logic [NS-1:0] s, p, np, nov;
        logic e, c;
        s = m_hist[S-1];
        p = m_hist[S];
        np = m_pend; nov = m_ov;
        for (int i = 0; i < NS; i++) begin
            e = pol[i] ? (!s[i] && p[i]) : (s[i] && !p[i]);
            c = sw_clr[i] || (cv && (int'(cid) == i));
            if (sw_clr[i]) nov[i] = 1'b0;
            if (!le[i]) begin
                np[i] = s[i] ^ pol[i];
            end else begin
                if (e || sw_set[i]) np[i] = 1'b1;
                else if (c)         np[i] = 1'b0;
                if (e && m_pend[i] && !c) nov[i] = 1'b1;
            end
        end
        m_pend = np;
        m_ov   = nov;
        m_err  = cv && (int'(cid) >= NS);
        for (int k = S; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = irq;
    endtask

    task automatic idle_inputs();
        sw_set = '0; sw_clr = '0; cv = 1'b0; cid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [NS-1:0] oh;
        model_reset();
        // reset state
        @(negedge clk);
        check("reset_ip", 32'(ip), 32'h0);
        check("reset_ov", 32'(ov), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        //  n  irq        le  pol        set        clr        cv cid     ip         ov         err
        add(2, 20'h00008, LA, Z,         Z,         Z,         0, 5'd0,  Z,         Z,         0);
        add(3, 20'h00008, LA, Z,         Z,         Z,         0, 5'd0,  20'h00008, Z,         0);
        add(1, 20'h00008, LA, Z,         Z,         Z,         1, 5'd3,  Z,         Z,         0);
        add(1, 20'h00008, LA, Z,         Z,         Z,         0, 5'd0,  Z,         Z,         0);
        add(2, 20'h00028, LA, Z,         Z,         Z,         0, 5'd0,  Z,         Z,         0);
        add(1, 20'h00028, LA, Z,         Z,         Z,         0, 5'd0,  20'h00020, Z,         0);
        add(3, 20'h00008, LA, Z,         Z,         Z,         0, 5'd0,  20'h00020, Z,         0);
        add(2, 20'h00028, LA, Z,         Z,         Z,         0, 5'd0,  20'h00020, Z,         0);
        add(1, 20'h00028, LA, Z,         Z,         Z,         1, 5'd5,  20'h00020, Z,         0);
        add(3, 20'h00008, LA, Z,         Z,         Z,         0, 5'd0,  20'h00020, Z,         0);
        add(2, 20'h00028, LA, Z,         Z,         Z,         0, 5'd0,  20'h00020, Z,         0);
        add(1, 20'h00028, LA, Z,         Z,         Z,         0, 5'd0,  20'h00020, 20'h00020, 0);
        add(1, 20'h00028, LA, Z,         Z,         20'h00020, 0, 5'd0,  Z,         Z,         0);
        add(2, 20'h00028, LA, 20'h0000C, Z,         Z,         0, 5'd0,  Z,         Z,         0);
        add(1, 20'h00028, LA, Z,         20'h00002, Z,         0, 5'd0,  20'h00002, Z,         0);
        add(1, 20'h00028, LA, Z,         Z,         Z,         1, 5'd20, 20'h00002, Z,         1);
        add(1, 20'h00028, LA, Z,         Z,         Z,         0, 5'd0,  20'h00002, Z,         0);
        add(3, 20'h000A8, LA, 20'h00080, Z,         Z,         0, 5'd0,  20'h00002, Z,         0);
        add(1, 20'h000A8, L7, 20'h00080, Z,         Z,         0, 5'd0,  20'h00002, Z,         0);
        add(2, 20'h00028, L7, 20'h00080, Z,         Z,         0, 5'd0,  20'h00002, Z,         0);
        add(1, 20'h00028, L7, 20'h00080, Z,         Z,         0, 5'd0,  20'h00082, Z,         0);
        add(1, 20'h00028, L7, 20'h00080, Z,         Z,         1, 5'd7,  20'h00082, Z,         0);
        add(2, 20'h000A8, L7, 20'h00080, Z,         Z,         0, 5'd0,  20'h00082, Z,         0);
        add(1, 20'h000A8, L7, 20'h00080, Z,         Z,         0, 5'd0,  20'h00002, Z,         0);

        foreach (tab[r]) begin
            irq = tab[r].irq; le = tab[r].le; pol = tab[r].pol;
            sw_set = tab[r].set; sw_clr = tab[r].clr; cv = tab[r].cv; cid = tab[r].cid;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tab%0d_ip", r), 32'(ip), 32'(tab[r].ip));
            check($sformatf("tab%0d_ov", r), 32'(ov), 32'(tab[r].ov));
            check($sformatf("tab%0d_err", r), 32'(err), 32'(tab[r].err));
        end

        // ---------------- randomized run against the model ----------------
        irq = '0; le = LA; pol = '0; idle_inputs();
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            idle_inputs();
            if ($urandom_range(0, 2) == 0) begin
                oh = '0; oh[$urandom_range(0, NS-1)] = 1'b1; irq = irq ^ oh;
            end
            if ($urandom_range(0, 15) == 0) begin
                oh = '0; oh[$urandom_range(0, NS-1)] = 1'b1; le = le ^ oh;
            end
            if ($urandom_range(0, 15) == 0) begin
                oh = '0; oh[$urandom_range(0, NS-1)] = 1'b1; pol = pol ^ oh;
            end
            if ($urandom_range(0, 7) == 0) begin
                oh = '0; oh[$urandom_range(0, NS-1)] = 1'b1; sw_set = oh;
            end
            if ($urandom_range(0, 7) == 0) begin
                oh = '0; oh[$urandom_range(0, NS-1)] = 1'b1; sw_clr = oh;
            end
            if ($urandom_range(0, 2) == 0) begin
                cv = 1'b1; cid = IW'($urandom_range(0, 31));
            end
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("rand_ip", 32'(ip), 32'(m_pend));
            check("rand_ov", 32'(ov), 32'(m_ov));
            check("rand_err", 32'(err), 32'(m_err));
        end

        // ---------------- async reset mid-operation ----------------
        idle_inputs();
        le = LA;
        sw_set = LA;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("preset_ip", 32'(ip), 32'(m_pend));
        sw_set = '0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_ip", 32'(ip), 32'h0);
        check("async_rst_ov", 32'(ov), 32'h0);
        check("async_rst_err", 32'(err), 32'h0);

        // sources held high through reset: pol=1 gives nothing, pol=0 sees a rising edge
        irq = LA; pol = 20'hFFFF0; le = LA;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("post_rst_c%0d_ip", c), 32'(ip), (c >= 3) ? 32'h0000F : 32'h0);
            check($sformatf("post_rst_c%0d_ov", c), 32'(ov), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
